// File: rtl/nand_bit_collector_pkg.sv
// Shared definitions for the NAND-stage bit collector.
// Provides the FSM state encoding, default sizing constants and the
// helper that derives the bit-index width from the word width.
package nand_bit_collector_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultCntW  = 8;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,  // output register free
    StHold  = 2'b01,  // output register full, shift register collecting
    StStall = 2'b10   // both buffers full
  } state_e;

  function automatic int unsigned idx_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/nand_bit_collector_if.sv
// Bit-stream input and word-stream output of the collector.
//   bit_in/bit_valid/bit_ready          : serial valid/ready input
//   word_out/word_valid/word_ready      : parallel valid/ready output
//   word_cnt                            : delivered-word counter
// slave modport is the collector, master modport is its environment.
interface nand_bit_collector_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid, word_cnt
  );

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid, word_cnt
  );
endinterface

// File: rtl/nand_bit_collector_shifter.sv
// Shift register and bit index of the collector.
//   clk, rst_n : clock, async active-low reset
//   accept     : write bit_in at the current index and advance
//   bit_in     : serial data bit
//   clear      : return the index to 0 (combined with accept on the last bit)
//   word       : register contents including a bit being accepted this cycle
//   last       : the current index is the final bit position
module nand_bit_shifter
  import nand_bit_collector_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             bit_in,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             last
);
  localparam int unsigned IdxW = idx_width(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (accept) begin
      sr_d[idx_q] = bit_in;
      idx_d       = idx_q + IdxW'(1);
    end
    if (clear) begin
      idx_d = '0;
    end
  end

  // Exposing the next value lets the top load a word in the same edge as its final bit.
  assign word = sr_d;
  assign last = (idx_q == IdxW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/nand_bit_collector.sv
// Collects serial bits from a NAND gate stage, LSB first, into WIDTH-bit words.
// Double-buffered: the shift register keeps filling while the output register
// waits for the consumer. Counts delivered words modulo 2^CNT_W.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of nand_bit_collector_if (bit and word streams)
// bit_in is used as-is; an asynchronous source needs an external synchroniser.
module nand_bit_collector
  import nand_bit_collector_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_bit_collector_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sr_word;
  logic             sr_last;
  logic             bit_ready;
  logic             word_valid;
  logic             accept;
  logic             last_acc;
  logic             deliver;
  logic             load;

  assign bit_ready  = (state_q != StStall);
  assign word_valid = (state_q == StHold) || (state_q == StStall);
  assign accept     = bus.bit_valid && bit_ready;
  assign last_acc   = accept && sr_last;
  assign deliver    = word_valid && bus.word_ready;

  nand_bit_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .bit_in (bus.bit_in),
    .clear  (last_acc),
    .word   (sr_word),
    .last   (sr_last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (last_acc) begin
          load    = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (last_acc && deliver) begin
          load = 1'b1;
        end else if (last_acc) begin
          state_d = StStall;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StStall: begin
        // No bit is accepted here, so sr_word is the frozen full register.
        if (deliver) begin
          load    = 1'b1;
          state_d = StHold;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        word_q <= sr_word;
      end
      if (deliver) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.bit_ready  = bit_ready;
  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid;
  assign bus.word_cnt   = cnt_q;
endmodule

// File: tb/tb_nand_bit_collector.sv
module tb_nand_bit_collector;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nand_bit_collector_if #(.WIDTH(8), .CNT_W(8)) bus ();
  nand_bit_collector_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  nand_bit_collector #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  nand_bit_collector #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         last_wait;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every delivery handshake pops the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.word_valid && bus.word_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $error("FAIL deliver_unexpected: observed %0h expected none", bus.word_out);
      end else begin
        check("deliver_word", {24'h0, bus.word_out}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one bit and returns once it has been accepted (bounded wait).
  task automatic send_bit(input logic b);
    logic rdy;
    int   n;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.bit_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    last_wait = n;
    if (!rdy) check("bit_accept_timeout", {31'h0, rdy}, 32'h1);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    sb.delete();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w[4];
    logic [3:0] v;
    int         exp_cnt[5];
    exp_cnt = '{1, 2, 3, 0, 1};

    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.word_ready  = 1'b0;
    bus2.bit_in     = 1'b0;
    bus2.bit_valid  = 1'b0;
    bus2.word_ready = 1'b1;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_word_out", {24'h0, bus.word_out}, 32'h0);
    check("rst_word_valid", {31'h0, bus.word_valid}, 32'h0);
    check("rst_word_cnt", {24'h0, bus.word_cnt}, 32'h0);
    check("rst_bit_ready", {31'h0, bus.bit_ready}, 32'h1);

    // Single word 8'h4D with word_ready held high throughout
    bus.word_ready = 1'b1;
    sb.push_back(8'h4D);
    for (int i = 0; i < 7; i++) send_bit(i inside {0, 2, 3, 6});
    check("t1_no_early_valid", {31'h0, bus.word_valid}, 32'h0);
    check("t1_cnt_idle_ready", {24'h0, bus.word_cnt}, 32'h0);
    send_bit(1'b0);
    bus.bit_valid = 1'b0;
    check("t1_valid_rise", {31'h0, bus.word_valid}, 32'h1);
    check("t1_word", {24'h0, bus.word_out}, 32'h4D);
    tick();
    check("t1_valid_fall", {31'h0, bus.word_valid}, 32'h0);
    check("t1_cnt", {24'h0, bus.word_cnt}, 32'h1);

    // Stall: 16 bits with consumer not ready
    do_reset();
    sb.push_back(8'hFF);
    sb.push_back(8'hA5);
    send_word(8'hFF);
    send_word(8'hA5);
    check("t2_stall_ready", {31'h0, bus.bit_ready}, 32'h0);
    check("t2_hold_ff", {24'h0, bus.word_out}, 32'hFF);
    bus.bit_in = 1'b1;
    repeat (3) tick();
    check("t2_still_stalled", {31'h0, bus.bit_ready}, 32'h0);
    check("t2_still_ff", {24'h0, bus.word_out}, 32'hFF);
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    bus.bit_valid  = 1'b0;
    check("t2_word_a5", {24'h0, bus.word_out}, 32'hA5);
    check("t2_valid_stays", {31'h0, bus.word_valid}, 32'h1);
    check("t2_ready_back", {31'h0, bus.bit_ready}, 32'h1);
    check("t2_cnt", {24'h0, bus.word_cnt}, 32'h1);
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    check("t2_cnt_drain", {24'h0, bus.word_cnt}, 32'h2);

    // Back-to-back: last bit of each new word coincides with delivery
    do_reset();
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      sb.push_back(w[k]);
      for (int i = 0; i < 8; i++) begin
        if (k > 0 && i == 7) bus.word_ready = 1'b1;
        send_bit(w[k][i]);
        bus.word_ready = 1'b0;
        if (k > 0) begin
          check("t3_valid_kept", {31'h0, bus.word_valid}, 32'h1);
          check("t3_no_stall", last_wait, 32'h1);
        end
      end
    end
    bus.bit_valid = 1'b0;
    check("t3_last_word", {24'h0, bus.word_out}, {24'h0, w[3]});
    check("t3_cnt3", {24'h0, bus.word_cnt}, 32'h3);
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    check("t3_cnt4", {24'h0, bus.word_cnt}, 32'h4);
    check("t3_empty", {31'h0, bus.word_valid}, 32'h0);

    // Gaps in bit_valid across 8'h3C
    do_reset();
    sb.push_back(8'h3C);
    for (int i = 0; i < 8; i++) begin
      send_bit(i inside {2, 3, 4, 5});
      bus.bit_valid = 1'b0;
      repeat (2) tick();
      if (i < 7) check("t4_gap_no_word", {31'h0, bus.word_valid}, 32'h0);
    end
    check("t4_word", {24'h0, bus.word_out}, 32'h3C);
    check("t4_valid", {31'h0, bus.word_valid}, 32'h1);

    // Asynchronous reset mid-word, output register still full of 8'h3C
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus.bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", {31'h0, bus.word_valid}, 32'h0);
    check("t5_async_word", {24'h0, bus.word_out}, 32'h0);
    check("t5_async_ready", {31'h0, bus.bit_ready}, 32'h1);
    check("t5_async_cnt", {24'h0, bus.word_cnt}, 32'h0);
    sb.delete();
    #1 rst_n = 1'b1;
    tick();
    sb.push_back(8'h81);
    send_word(8'h81);
    bus.bit_valid = 1'b0;
    check("t5_word", {24'h0, bus.word_out}, 32'h81);
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    check("t5_cnt", {24'h0, bus.word_cnt}, 32'h1);

    // CNT_W=2 instance: counter wraps after 4 deliveries
    for (int k = 0; k < 5; k++) begin
      v = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        bus2.bit_in    = v[i];
        bus2.bit_valid = 1'b1;
        tick();
      end
      bus2.bit_valid = 1'b0;
      check("t6_word", {28'h0, bus2.word_out}, {28'h0, v});
      check("t6_valid", {31'h0, bus2.word_valid}, 32'h1);
      tick();
      check("t6_cnt", {30'h0, bus2.word_cnt}, 32'(exp_cnt[k]));
    end

    check("sb_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
